// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle.
// Start/done handshake; overflow flags values that need more than DIGITS digits.
module bin2bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t               state, state_nxt;
    logic [BIN_W-1:0]     bin_work;
    logic [4*DIGITS-1:0]  bcd_work;
    logic [4*DIGITS-1:0]  adj;
    logic [4*DIGITS-1:0]  bcd_shift;
    logic                 ovf_work;
    logic                 ovf_nxt;
    logic [CW-1:0]        cnt;
    logic                 last_iter;

    assign last_iter = (cnt == CW'(BIN_W - 1));

    // add-3 correction on every digit, then one left shift of the whole chain
    always_comb begin
        adj = bcd_work;
        for (int d = 0; d < DIGITS; d++) begin
            if (adj[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
        end
    end

    assign bcd_shift = {adj[4*DIGITS-2:0], bin_work[BIN_W-1]};
    assign ovf_nxt   = ovf_work | adj[4*DIGITS-1];

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SHIFT;
            S_SHIFT: if (last_iter) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready = (state == S_IDLE);
        busy  = (state == S_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bin_work <= '0;
            bcd_work <= '0;
            ovf_work <= 1'b0;
            cnt      <= '0;
            bcd      <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bin_work <= bin;
                        bcd_work <= '0;
                        ovf_work <= 1'b0;
                        cnt      <= '0;
                    end
                end
                S_SHIFT: begin
                    bcd_work <= bcd_shift;
                    bin_work <= bin_work << 1;
                    ovf_work <= ovf_nxt;
                    cnt      <= cnt + 1'b1;
                    if (last_iter) begin
                        bcd      <= bcd_shift;
                        overflow <= ovf_nxt;
                        done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: four parameterisations share clock and reset,
// each with its own expected-result queue drained by a monitor on done.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // a: 16/5, b: 8/2, c: 1/1, d: 10/4
    logic        start_a = 0, start_b = 0, start_c = 0, start_d = 0;
    logic [15:0] bin_a = 0;
    logic [7:0]  bin_b = 0;
    logic [0:0]  bin_c = 0;
    logic [9:0]  bin_d = 0;
    logic        ready_a, ready_b, ready_c, ready_d;
    logic        busy_a, busy_b, busy_c, busy_d;
    logic        done_a, done_b, done_c, done_d;
    logic        ovf_a, ovf_b, ovf_c, ovf_d;
    logic [19:0] bcd_a;
    logic [7:0]  bcd_b;
    logic [3:0]  bcd_c;
    logic [15:0] bcd_d;

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_a (.clk(clk), .reset(reset), .start(start_a), .bin(bin_a),
        .ready(ready_a), .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a));
    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_b (.clk(clk), .reset(reset), .start(start_b), .bin(bin_b),
        .ready(ready_b), .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b));
    bin2bcd_seq #(.BIN_W(1), .DIGITS(1)) u_c (.clk(clk), .reset(reset), .start(start_c), .bin(bin_c),
        .ready(ready_c), .busy(busy_c), .done(done_c), .bcd(bcd_c), .overflow(ovf_c));
    bin2bcd_seq #(.BIN_W(10), .DIGITS(4)) u_d (.clk(clk), .reset(reset), .start(start_d), .bin(bin_d),
        .ready(ready_d), .busy(busy_d), .done(done_d), .bcd(bcd_d), .overflow(ovf_d));

    // expected entries are {overflow, bcd zero-extended to 32 bits}
    logic [32:0] q_a[$], q_b[$], q_c[$], q_d[$];

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon(input string name, inout logic [32:0] q[$], input logic [32:0] act);
        if (q.size() == 0) chk({name, " unexpected done"}, act, 33'h1_ffff_ffff);
        else chk(name, act, q.pop_front());
    endtask

    always @(negedge clk) if (done_a) mon("a", q_a, {ovf_a, 12'd0, bcd_a});
    always @(negedge clk) if (done_b) mon("b", q_b, {ovf_b, 24'd0, bcd_b});
    always @(negedge clk) if (done_c) mon("c", q_c, {ovf_c, 28'd0, bcd_c});
    always @(negedge clk) if (done_d) mon("d", q_d, {ovf_d, 16'd0, bcd_d});

    function automatic logic rdy(input int id);
        case (id)
            0: return ready_a;
            1: return ready_b;
            2: return ready_c;
            default: return ready_d;
        endcase
    endfunction

    // waits for ready (bounded), then presents one start; returns 1ns after the accepting edge
    task automatic go(input int id, input logic [31:0] v);
        int n = 0;
        @(negedge clk);
        while (!rdy(id) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready timeout", 33'd0, 33'd1);
        case (id)
            0: begin start_a = 1; bin_a = v[15:0]; end
            1: begin start_b = 1; bin_b = v[7:0]; end
            2: begin start_c = 1; bin_c = v[0:0]; end
            default: begin start_d = 1; bin_d = v[9:0]; end
        endcase
        @(posedge clk);
        #1;
        start_a = 0; start_b = 0; start_c = 0; start_d = 0;
    endtask

    function automatic logic [32:0] ref_bcd(input int v, input int digits);
        logic [31:0] r = 0;
        int t = v;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return {t != 0, r};
    endfunction

    task automatic done_latency(input string name, input int id, input int exp_edges);
        int n = 0;
        logic seen = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            seen = (id == 0) ? done_a : done_c;
        end
        chk(name, 33'(n), 33'(exp_edges));
    endtask

    initial begin
        int n;
        int pulses;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("reset ready/busy/done a", {ready_a, busy_a, done_a}, 33'b100);
        chk("reset bcd/ovf a", {ovf_a, 12'd0, bcd_a}, 33'd0);
        chk("reset ready/busy/done c", {ready_c, busy_c, done_c}, 33'b100);

        // latency: done observed at edge BIN_W+1 after accept
        q_a.push_back({1'b0, 32'h00000});
        go(0, 0);
        done_latency("latency a", 0, 17);
        q_a.push_back({1'b0, 32'h65535}); go(0, 65535);
        q_a.push_back({1'b0, 32'h12345}); go(0, 12345);
        q_a.push_back({1'b0, 32'h00009}); go(0, 9);

        q_b.push_back({1'b0, 32'h99}); go(1, 99);
        q_b.push_back({1'b1, 32'h00}); go(1, 100);
        q_b.push_back({1'b1, 32'h55}); go(1, 255);

        q_c.push_back({1'b0, 32'h1});
        go(2, 1);
        done_latency("latency c", 2, 2);
        q_c.push_back({1'b0, 32'h0}); go(2, 0);

        // start held high across a conversion while bin changes
        q_a.push_back({1'b0, 32'h00500});
        q_a.push_back({1'b0, 32'h00007});
        repeat (20) @(posedge clk);
        @(negedge clk);
        start_a = 1; bin_a = 16'd500;
        @(posedge clk);
        #1 bin_a = 16'd7;
        n = 0;
        @(negedge clk);
        while (!ready_a && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("ready low cycles", 33'(n), 33'd17);
        chk("busy after return", {31'd0, busy_a, ready_a}, 33'b01);
        @(posedge clk);
        #1 start_a = 0;
        repeat (22) @(posedge clk);

        // reset at iteration 8 discards the conversion
        go(0, 4321);
        repeat (7) @(posedge clk);
        #1 reset = 1;
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("post-reset ready", {32'd0, ready_a}, 33'd1);
        chk("post-reset bcd/ovf", {ovf_a, 12'd0, bcd_a}, 33'd0);
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (done_a) pulses++;
        end
        chk("done after reset", 33'(pulses), 33'd0);
        q_a.push_back({1'b0, 32'h00042}); go(0, 42);

        // full sweep of the 10-bit instance against the decimal model
        for (int v = 0; v < 1024; v++) begin
            q_d.push_back(ref_bcd(v, 4));
            go(3, v);
        end

        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("queues drained", 33'(q_a.size() + q_b.size() + q_c.size() + q_d.size()), 33'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
